ps2_ascii_queue: RTL and testbench

Scan-code-to-character decoder and buffer between the PS/2 keyboard controller and its consumers (LCD controller, processor I/O). It tracks make/break/extended prefixes and shift state, converts key presses into ASCII, and queues the characters in a parametrised FIFO. The FIFO drains over a valid/ready handshake, so no keystroke is lost while the consumer is busy. It replaces the single-byte combinational scan-code lookup, which reported only the last byte seen, treated releases as presses and emitted space for unknown codes.

---
 rtl/ps2_kbd_pkg.sv | 57 +++++
 rtl/ps2_ascii_queue_if.sv | 24 ++
 rtl/ps2_char_fifo.sv | 59 +++++
 rtl/ps2_ascii_queue.sv | 131 +++++++++++++
 tb/tb_ps2_ascii_queue.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/ps2_kbd_pkg.sv
// Shared PS/2 keyboard definitions: prefix FSM encoding, scan-code
// constants and the set-2 scan-code to ASCII lookup.
package ps2_kbd_pkg;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_BREAK     = 2'd1;
    localparam logic [1:0] ST_EXT       = 2'd2;
    localparam logic [1:0] ST_EXT_BREAK = 2'd3;

    localparam logic [7:0] SC_BREAK   = 8'hF0;
    localparam logic [7:0] SC_EXT     = 8'hE0;
    localparam logic [7:0] SC_BAT_OK  = 8'hAA;
    localparam logic [7:0] SC_ACK     = 8'hFA;
    localparam logic [7:0] SC_SHIFT_L = 8'h12;
    localparam logic [7:0] SC_SHIFT_R = 8'h59;
    localparam logic [7:0] SC_EXT_DEL = 8'h71;
    localparam logic [7:0] SC_BKSP    = 8'h66;
    localparam logic [7:0] SC_ENTER   = 8'h5A;
    localparam logic [7:0] SC_SPACE   = 8'h29;

    typedef struct packed {
        logic       hit;
        logic [7:0] ch;
    } ps2_lookup_t;

    // Make code to ASCII; hit=0 for codes that produce no character.
    function automatic ps2_lookup_t scan_to_ascii(input logic [7:0] code, input logic upper);
        ps2_lookup_t r;
        r.hit = 1'b1;
        r.ch  = 8'd0;
        case (code)
            8'h1C: r.ch = 8'd97;   8'h32: r.ch = 8'd98;   8'h21: r.ch = 8'd99;
            8'h23: r.ch = 8'd100;  8'h24: r.ch = 8'd101;  8'h2B: r.ch = 8'd102;
            8'h34: r.ch = 8'd103;  8'h33: r.ch = 8'd104;  8'h43: r.ch = 8'd105;
            8'h3B: r.ch = 8'd106;  8'h42: r.ch = 8'd107;  8'h4B: r.ch = 8'd108;
            8'h3A: r.ch = 8'd109;  8'h31: r.ch = 8'd110;  8'h44: r.ch = 8'd111;
            8'h4D: r.ch = 8'd112;  8'h15: r.ch = 8'd113;  8'h2D: r.ch = 8'd114;
            8'h1B: r.ch = 8'd115;  8'h2C: r.ch = 8'd116;  8'h3C: r.ch = 8'd117;
            8'h2A: r.ch = 8'd118;  8'h1D: r.ch = 8'd119;  8'h22: r.ch = 8'd120;
            8'h35: r.ch = 8'd121;  8'h1A: r.ch = 8'd122;
            8'h45: r.ch = 8'd48;   8'h16: r.ch = 8'd49;   8'h1E: r.ch = 8'd50;
            8'h26: r.ch = 8'd51;   8'h25: r.ch = 8'd52;   8'h2E: r.ch = 8'd53;
            8'h36: r.ch = 8'd54;   8'h3D: r.ch = 8'd55;   8'h3E: r.ch = 8'd56;
            8'h46: r.ch = 8'd57;
            SC_SPACE: r.ch = 8'd32;
            SC_BKSP:  r.ch = 8'd127;
            SC_ENTER: r.ch = 8'd13;
            default:  r.hit = 1'b0;
        endcase
        // Only the lowercase letter range is shifted; digits and controls never fall in it.
        if (upper && r.ch >= 8'd97 && r.ch <= 8'd122) begin
            r.ch = r.ch - 8'd32;
        end
        return r;
    endfunction

endpackage

// File: rtl/ps2_ascii_queue_if.sv
// Scan-byte input and character-stream output bundle of ps2_ascii_queue.
// master = keyboard controller / consumer side, slave = the queue itself.
interface ps2_ascii_queue_if #(
    parameter int FIFO_DEPTH = 16,
    parameter int CHAR_W     = 8
) ();
    logic                          key_valid;
    logic [7:0]                    key_code;
    logic                          out_ready;
    logic                          out_valid;
    logic [CHAR_W-1:0]             out_char;
    logic [$clog2(FIFO_DEPTH):0]   fifo_count;
    logic                          overflow;

    modport master (
        output key_valid, key_code, out_ready,
        input  out_valid, out_char, fifo_count, overflow
    );

    modport slave (
        input  key_valid, key_code, out_ready,
        output out_valid, out_char, fifo_count, overflow
    );
endinterface

// File: rtl/ps2_char_fifo.sv
// Show-ahead character FIFO: head entry is visible combinationally,
// rd_data reads 0 while empty. A push into a full FIFO is accepted only
// when a pop happens in the same cycle; otherwise it is reported on drop.
module ps2_char_fifo #(
    parameter int FIFO_DEPTH = 16,
    parameter int CHAR_W     = 8
) (
    input  logic                          clock,
    input  logic                          resetn,
    input  logic                          push,
    input  logic [CHAR_W-1:0]             push_data,
    input  logic                          pop,
    output logic [CHAR_W-1:0]             rd_data,
    output logic                          empty,
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          drop
);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [CHAR_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_reg;
    logic [AW-1:0]     rd_ptr_reg;
    logic [AW:0]       count_reg;
    logic              wr_en;
    logic              pop_en;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == (AW+1)'(FIFO_DEPTH));
    assign pop_en  = pop && !empty;
    assign wr_en   = push && (!full || pop_en);
    assign drop    = push && !wr_en;
    assign count   = count_reg;
    assign rd_data = empty ? '0 : mem[rd_ptr_reg];

    // Storage write; contents need no reset since count gates visibility.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (wr_en)  wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop_en) rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({wr_en, pop_en})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end
endmodule

// File: rtl/ps2_ascii_queue.sv
// PS/2 set-2 scan bytes -> queued ASCII characters.
// Tracks F0/E0 prefixes, converts make codes and buffers the result.
// Optional feature macro: PS2_SHIFT_EN (shift keys give uppercase letters).
module ps2_ascii_queue #(
    parameter int FIFO_DEPTH = 16,
    parameter int CHAR_W     = 8
) (
    input  logic               clock,
    input  logic               resetn,
    ps2_ascii_queue_if.slave   bus
);
    import ps2_kbd_pkg::*;

    logic [1:0]        state_reg;
    logic [1:0]        state_next;
    logic              overflow_reg;
    logic              push;
    logic [7:0]        push_char;
    logic              upper;
    logic              fifo_empty;
    logic              fifo_full;
    logic              fifo_drop;
    ps2_lookup_t       lk;

`ifdef PS2_SHIFT_EN
    logic shift_l_reg, shift_l_next;
    logic shift_r_reg, shift_r_next;
    assign upper = shift_l_reg | shift_r_reg;
`else
    assign upper = 1'b0;
`endif

    assign lk = scan_to_ascii(bus.key_code, upper);

    // Prefix FSM: decides next state, shift updates and whether to push.
    always_comb begin
        state_next = state_reg;
        push       = 1'b0;
        push_char  = 8'd0;
`ifdef PS2_SHIFT_EN
        shift_l_next = shift_l_reg;
        shift_r_next = shift_r_reg;
`endif
        if (bus.key_valid) begin
            case (state_reg)
                ST_IDLE: begin
                    if (bus.key_code == SC_BREAK) begin
                        state_next = ST_BREAK;
                    end else if (bus.key_code == SC_EXT) begin
                        state_next = ST_EXT;
                    end else if (bus.key_code == SC_SHIFT_L) begin
`ifdef PS2_SHIFT_EN
                        shift_l_next = 1'b1;
`endif
                    end else if (bus.key_code == SC_SHIFT_R) begin
`ifdef PS2_SHIFT_EN
                        shift_r_next = 1'b1;
`endif
                    end else if (bus.key_code != SC_BAT_OK && bus.key_code != SC_ACK) begin
                        push      = lk.hit;
                        push_char = lk.ch;
                    end
                end
                ST_BREAK: begin
`ifdef PS2_SHIFT_EN
                    if (bus.key_code == SC_SHIFT_L) shift_l_next = 1'b0;
                    if (bus.key_code == SC_SHIFT_R) shift_r_next = 1'b0;
`endif
                    state_next = ST_IDLE;
                end
                ST_EXT: begin
                    if (bus.key_code == SC_BREAK) begin
                        state_next = ST_EXT_BREAK;
                    end else begin
                        state_next = ST_IDLE;
                        if (bus.key_code == SC_EXT_DEL) begin
                            push      = 1'b1;
                            push_char = 8'd127;
                        end
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // FSM state and shift flags; reset also drops any pending prefix.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_reg <= ST_IDLE;
`ifdef PS2_SHIFT_EN
            shift_l_reg <= 1'b0;
            shift_r_reg <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
`ifdef PS2_SHIFT_EN
            shift_l_reg <= shift_l_next;
            shift_r_reg <= shift_r_next;
`endif
        end
    end

    // Sticky overflow: set whenever a decoded character could not be queued.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            overflow_reg <= 1'b0;
        end else if (fifo_drop) begin
            overflow_reg <= 1'b1;
        end
    end

    ps2_char_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .CHAR_W     (CHAR_W)
    ) u_fifo (
        .clock     (clock),
        .resetn    (resetn),
        .push      (push),
        .push_data (CHAR_W'(push_char)),
        .pop       (bus.out_ready),
        .rd_data   (bus.out_char),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .count     (bus.fifo_count),
        .drop      (fifo_drop)
    );

    assign bus.out_valid = !fifo_empty;
    assign bus.overflow  = overflow_reg;
endmodule

// File: tb/tb_ps2_ascii_queue.sv
// Self-checking bench for ps2_ascii_queue (FIFO_DEPTH=4): table of single
// key press/release vectors plus hand-written prefix, shift and FIFO cases.
module tb_ps2_ascii_queue;
    localparam int DEPTH = 4;

    logic clock = 1'b0;
    logic resetn;
    always #5 clock = ~clock;

    ps2_ascii_queue_if #(.FIFO_DEPTH(DEPTH), .CHAR_W(8)) bus ();

    ps2_ascii_queue #(.FIFO_DEPTH(DEPTH), .CHAR_W(8)) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    typedef struct {
        logic [7:0] code;
        bit         hit;
        logic [7:0] ch;
    } vec_t;

    vec_t vecs[14];
    int   sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clock);
        bus.key_valid = 1'b1;
        bus.key_code  = b;
        @(negedge clock);
        bus.key_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clock);
        resetn = 1'b0;
        @(negedge clock);
        resetn = 1'b1;
        sb.delete();
    endtask

    // Pops every character the model expects, comparing at each handshake.
    task automatic drain(input string name);
        int n;
        n = sb.size();
        for (int i = 0; i < n; i++) begin
            check({name, "_valid"}, 32'(bus.out_valid), 32'd1);
            check({name, "_char"},  32'(bus.out_char), 32'(sb[0]));
            bus.out_ready = 1'b1;
            @(negedge clock);
            bus.out_ready = 1'b0;
            void'(sb.pop_front());
        end
        check({name, "_empty"}, 32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        vecs[0]  = '{8'h1C, 1'b1, 8'd97};
        vecs[1]  = '{8'h1A, 1'b1, 8'd122};
        vecs[2]  = '{8'h4D, 1'b1, 8'd112};
        vecs[3]  = '{8'h45, 1'b1, 8'd48};
        vecs[4]  = '{8'h16, 1'b1, 8'd49};
        vecs[5]  = '{8'h46, 1'b1, 8'd57};
        vecs[6]  = '{8'h29, 1'b1, 8'd32};
        vecs[7]  = '{8'h66, 1'b1, 8'd127};
        vecs[8]  = '{8'h5A, 1'b1, 8'd13};
        vecs[9]  = '{8'h0E, 1'b0, 8'd0};
        vecs[10] = '{8'h76, 1'b0, 8'd0};
        vecs[11] = '{8'h12, 1'b0, 8'd0};
        vecs[12] = '{8'h59, 1'b0, 8'd0};
        vecs[13] = '{8'hAA, 1'b0, 8'd0};

        resetn        = 1'b0;
        bus.key_valid = 1'b0;
        bus.key_code  = 8'h00;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clock);
        resetn = 1'b1;

        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_char",  32'(bus.out_char), 32'd0);
        check("rst_count", 32'(bus.fifo_count), 32'd0);
        check("rst_ovf",   32'(bus.overflow), 32'd0);

        // Press + release of each table code: one character at most.
        for (int i = 0; i < 14; i++) begin
            send_byte(vecs[i].code);
            send_byte(8'hF0);
            send_byte(vecs[i].code);
            if (vecs[i].hit) sb.push_back(int'(vecs[i].ch));
            check($sformatf("vec%0d_count", i), 32'(bus.fifo_count), 32'(sb.size()));
            drain($sformatf("vec%0d", i));
        end

        // Shift held over one letter, released before the next.
        send_byte(8'h12); send_byte(8'h1C); send_byte(8'hF0); send_byte(8'h1C);
        send_byte(8'hF0); send_byte(8'h12); send_byte(8'h1C);
`ifdef PS2_SHIFT_EN
        sb.push_back(65);
`else
        sb.push_back(97);
`endif
        sb.push_back(97);
        check("shift_count", 32'(bus.fifo_count), 32'd2);
        drain("shift");

        // Extended codes: only E0 71 pushes; FSM must return to IDLE.
        send_byte(8'hE0); send_byte(8'h71);
        send_byte(8'hE0); send_byte(8'h75);
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
        send_byte(8'h29);
        sb.push_back(127);
        sb.push_back(32);
        check("ext_count", 32'(bus.fifo_count), 32'd2);
        drain("ext");

        // Overflow: six typematic presses into a depth-4 FIFO.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            send_byte(8'h1C);
            if (sb.size() < DEPTH) sb.push_back(97);
        end
        check("ovf_count", 32'(bus.fifo_count), 32'(DEPTH));
        check("ovf_flag",  32'(bus.overflow), 32'd1);
        drain("ovf");
        check("ovf_sticky", 32'(bus.overflow), 32'd1);
        do_reset();
        check("ovf_cleared", 32'(bus.overflow), 32'd0);

        // Full FIFO with simultaneous push and pop.
        send_byte(8'h1C); send_byte(8'h32); send_byte(8'h21); send_byte(8'h23);
        sb.push_back(97); sb.push_back(98); sb.push_back(99); sb.push_back(100);
        check("full_count", 32'(bus.fifo_count), 32'(DEPTH));
        @(negedge clock);
        bus.key_valid = 1'b1;
        bus.key_code  = 8'h24;
        bus.out_ready = 1'b1;
        check("full_pp_char", 32'(bus.out_char), 32'(sb[0]));
        void'(sb.pop_front());
        sb.push_back(101);
        @(negedge clock);
        bus.key_valid = 1'b0;
        bus.out_ready = 1'b0;
        check("full_pp_count", 32'(bus.fifo_count), 32'(DEPTH));
        check("full_pp_ovf",   32'(bus.overflow), 32'd0);
        drain("full_pp");

        // Empty FIFO with simultaneous push and out_ready.
        @(negedge clock);
        bus.key_valid = 1'b1;
        bus.key_code  = 8'h1C;
        bus.out_ready = 1'b1;
        @(negedge clock);
        bus.key_valid = 1'b0;
        bus.out_ready = 1'b0;
        sb.push_back(97);
        check("empty_pp_count", 32'(bus.fifo_count), 32'd1);
        drain("empty_pp");

        // Reset right after F0 discards the prefix; inputs during reset ignored.
        send_byte(8'hF0);
        @(negedge clock);
        resetn        = 1'b0;
        bus.key_valid = 1'b1;
        bus.key_code  = 8'h1C;
        bus.out_ready = 1'b1;
        @(negedge clock);
        resetn        = 1'b1;
        bus.key_valid = 1'b0;
        bus.out_ready = 1'b0;
        sb.delete();
        check("rstpfx_count0", 32'(bus.fifo_count), 32'd0);
        send_byte(8'h1C);
        sb.push_back(97);
        check("rstpfx_count1", 32'(bus.fifo_count), 32'd1);
        drain("rstpfx");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
